// File: rtl/gmii_tx_checker.sv
// gmii_tx_checker
//   Passive checker for the GMII transmit stream. It strips preamble/SFD,
//   checks the Ethernet FCS, measures the frame length and extracts the
//   EtherType and ARP opcode. It reports one registered status word per
//   burst.
//
// Ports
//   clk        : GMII transmit clock; all logic runs on its rising edge
//   reset      : synchronous, active-high
//   tx_en      : monitored GMII transmit enable
//   tx_data    : monitored GMII transmit data
//   frame_done : one-cycle pulse; status below is valid and held until the next pulse
//   frame_ok   : no error bit set for the last burst
//   err_pre    : preamble/SFD violation
//   err_crc    : FCS mismatch
//   err_runt   : length < MIN_LEN
//   err_long   : length > MAX_LEN
//   frame_len  : bytes after SFD through FCS (saturating)
//   ethertype  : bytes 12,13 (big-endian), 0 if not received
//   arp_oper   : bytes 20,21 when ethertype is ARP, else 0
//   frame_cnt  : number of frame_done pulses (wraps)
//   err_cnt    : number of frame_done pulses with frame_ok=0 (wraps)
module gmii_tx_checker #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522,
    parameter int PRE_MIN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_en,
    input  logic [7:0]  tx_data,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        err_pre,
    output logic        err_crc,
    output logic        err_runt,
    output logic        err_long,
    output logic [15:0] frame_len,
    output logic [15:0] ethertype,
    output logic [15:0] arp_oper,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [15:0] MIN_LEN_C   = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_C   = 16'(MAX_LEN);
    localparam logic [3:0]  PRE_MIN_C   = 4'(PRE_MIN);
    localparam logic [15:0] ETYPE_ARP   = 16'h0806;

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

    state_t              state, state_nxt;
    logic                end_burst;
    logic [3:0]          pre_cnt;
    logic [31:0]         crc;
    logic [15:0]         idx;
    logic [7:0]          b12, b13, b20, b21;

    // Reflected CRC-32, one byte per call, LSB first. Unrolls to a flat XOR network.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_comb begin
        state_nxt = state;
        end_burst = 1'b0;
        case (state)
            IDLE: begin
                if (tx_en)
                    state_nxt = (tx_data == 8'h55) ? PRE : DROP;
            end
            PRE: begin
                if (!tx_en) begin
                    state_nxt = IDLE;
                    end_burst = 1'b1;
                end else if (tx_data == 8'h55) begin
                    state_nxt = PRE;
                end else if (tx_data == 8'hD5 && pre_cnt >= PRE_MIN_C) begin
                    state_nxt = DATA;
                end else begin
                    state_nxt = DROP;
                end
            end
            DATA, DROP: begin
                if (!tx_en) begin
                    state_nxt = IDLE;
                    end_burst = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // End-of-burst status, evaluated from the state being left
    logic        vld_p0;
    logic        in_data_p0;
    logic        err_crc_p0, err_runt_p0, err_long_p0, err_pre_p0, ok_p0;
    logic [15:0] len_p0, etype_p0, oper_p0;

    always_comb begin
        vld_p0      = end_burst;
        in_data_p0  = (state == DATA);
        err_pre_p0  = !in_data_p0;
        err_crc_p0  = in_data_p0 && (crc != CRC_RESIDUE);
        err_runt_p0 = in_data_p0 && (idx < MIN_LEN_C);
        err_long_p0 = in_data_p0 && (idx > MAX_LEN_C);
        ok_p0       = !(err_pre_p0 || err_crc_p0 || err_runt_p0 || err_long_p0);
        len_p0      = in_data_p0 ? idx : 16'd0;
        etype_p0    = (in_data_p0 && idx >= 16'd14) ? {b12, b13} : 16'd0;
        oper_p0     = (etype_p0 == ETYPE_ARP && idx >= 16'd22) ? {b20, b21} : 16'd0;
    end

    // Data path: CRC, byte index and header shadows (no reset needed, seeded at SFD)
    always_ff @(posedge clk) begin
        if (state == PRE && state_nxt == DATA) begin
            crc <= 32'hFFFFFFFF;
            idx <= 16'd0;
            b12 <= 8'd0;
            b13 <= 8'd0;
            b20 <= 8'd0;
            b21 <= 8'd0;
        end else if (state == DATA && tx_en) begin
            crc <= crc32_byte(crc, tx_data);
            idx <= sat_inc16(idx);
            if (idx == 16'd12) b12 <= tx_data;
            if (idx == 16'd13) b13 <= tx_data;
            if (idx == 16'd20) b20 <= tx_data;
            if (idx == 16'd21) b21 <= tx_data;
        end
    end

    // Stage p0 -> registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pre_cnt    <= 4'd0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err_pre    <= 1'b0;
            err_crc    <= 1'b0;
            err_runt   <= 1'b0;
            err_long   <= 1'b0;
            frame_len  <= 16'd0;
            ethertype  <= 16'd0;
            arp_oper   <= 16'd0;
            frame_cnt  <= 16'd0;
            err_cnt    <= 16'd0;
        end else begin
            state      <= state_nxt;
            frame_done <= vld_p0;
            if (state == IDLE)
                pre_cnt <= 4'd1;
            else if (state == PRE && tx_en && tx_data == 8'h55)
                pre_cnt <= sat_inc4(pre_cnt);
            if (vld_p0) begin
                frame_ok  <= ok_p0;
                err_pre   <= err_pre_p0;
                err_crc   <= err_crc_p0;
                err_runt  <= err_runt_p0;
                err_long  <= err_long_p0;
                frame_len <= len_p0;
                ethertype <= etype_p0;
                arp_oper  <= oper_p0;
                frame_cnt <= frame_cnt + 16'd1;
                if (!ok_p0)
                    err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_gmii_tx_checker.sv
module tb_gmii_tx_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_en = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        frame_done, frame_ok, err_pre, err_crc, err_runt, err_long;
    logic [15:0] frame_len, ethertype, arp_oper, frame_cnt, err_cnt;

    gmii_tx_checker dut (
        .clk(clk), .reset(reset), .tx_en(tx_en), .tx_data(tx_data),
        .frame_done(frame_done), .frame_ok(frame_ok), .err_pre(err_pre),
        .err_crc(err_crc), .err_runt(err_runt), .err_long(err_long),
        .frame_len(frame_len), .ethertype(ethertype), .arp_oper(arp_oper),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ok, pre, crc, runt, lng;
        logic [15:0] len, et, op, fc, ec;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t ex;
    logic [7:0] pl[$];
    logic [7:0] bq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic set_exp(input logic ok, input logic pre, input logic crc, input logic runt,
                           input logic lng, input logic [15:0] len, input logic [15:0] et,
                           input logic [15:0] op, input logic [15:0] fc, input logic [15:0] ec);
        ex.ok = ok; ex.pre = pre; ex.crc = crc; ex.runt = runt; ex.lng = lng;
        ex.len = len; ex.et = et; ex.op = op; ex.fc = fc; ex.ec = ec; ex.cyc = 0;
    endtask

    task automatic build_arp();
        pl = {8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
              8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
              8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h01, 8'h01,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hc0, 8'ha8, 8'h01, 8'h02};
        while (pl.size() < 60) pl.push_back(8'h00);
    endtask

    task automatic build_ip(input int n);
        pl = {8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
              8'h08, 8'h00};
        while (pl.size() < n) pl.push_back(8'(pl.size() * 7));
    endtask

    // Standard Ethernet FCS over pl, appended least-significant byte first
    task automatic add_fcs();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (pl[i]) begin
            c = c ^ {24'd0, pl[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        pl.push_back(c[7:0]);
        pl.push_back(c[15:8]);
        pl.push_back(c[23:16]);
        pl.push_back(c[31:24]);
    endtask

    task automatic make_burst(input int npre);
        bq = {};
        for (int i = 0; i < npre; i++) bq.push_back(8'h55);
        bq.push_back(8'hD5);
        foreach (pl[i]) bq.push_back(pl[i]);
    endtask

    // Drive bq as one burst; optionally pulse reset alongside bq[rst_at]
    task automatic drive(input int rst_at, input int gap);
        for (int i = 0; i < bq.size(); i++) begin
            @(posedge clk);
            #1;
            if (rst_at >= 0 && i == rst_at + 1) begin
                chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
                chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
            end
            tx_en   = 1'b1;
            tx_data = bq[i];
            reset   = (i == rst_at);
        end
        @(posedge clk);
        #1;
        tx_en   = 1'b0;
        tx_data = 8'h00;
        reset   = 1'b0;
        ex.cyc  = cyc + 1;
        sbq.push_back(ex);
        for (int g = 1; g < gap; g++) @(posedge clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout actual=%0d pending required=0 pending", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic check_zero();
        chk("z_frame_done", {31'd0, frame_done}, 32'd0);
        chk("z_frame_ok", {31'd0, frame_ok}, 32'd0);
        chk("z_errs", {28'd0, err_pre, err_crc, err_runt, err_long}, 32'd0);
        chk("z_frame_len", {16'd0, frame_len}, 32'd0);
        chk("z_ethertype", {16'd0, ethertype}, 32'd0);
        chk("z_arp_oper", {16'd0, arp_oper}, 32'd0);
        chk("z_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("z_err_cnt", {16'd0, err_cnt}, 32'd0);
    endtask

    // Monitor: compare every frame_done pulse against the oldest expectation
    always @(negedge clk) begin
        if (frame_done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("latency_cycle", cyc, e.cyc);
                chk("frame_ok", {31'd0, frame_ok}, {31'd0, e.ok});
                chk("err_pre", {31'd0, err_pre}, {31'd0, e.pre});
                chk("err_crc", {31'd0, err_crc}, {31'd0, e.crc});
                chk("err_runt", {31'd0, err_runt}, {31'd0, e.runt});
                chk("err_long", {31'd0, err_long}, {31'd0, e.lng});
                chk("frame_len", {16'd0, frame_len}, {16'd0, e.len});
                chk("ethertype", {16'd0, ethertype}, {16'd0, e.et});
                chk("arp_oper", {16'd0, arp_oper}, {16'd0, e.op});
                chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, e.fc});
                chk("err_cnt", {16'd0, err_cnt}, {16'd0, e.ec});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero();

        // Good ARP request, 64 bytes
        build_arp(); add_fcs(); make_burst(7);
        set_exp(1, 0, 0, 0, 0, 16'd64, 16'h0806, 16'h0001, 16'd1, 16'd0);
        drive(-1, 3); wait_drain();

        // Same frame, byte 30 corrupted after FCS computed
        build_arp(); add_fcs(); pl[30] = pl[30] ^ 8'h01; make_burst(7);
        set_exp(0, 0, 1, 0, 0, 16'd64, 16'h0806, 16'h0001, 16'd2, 16'd1);
        drive(-1, 3); wait_drain();

        // Broken preamble
        bq = {8'h55, 8'h55, 8'h00};
        for (int i = 0; i < 20; i++) bq.push_back(8'(i * 13 + 1));
        set_exp(0, 1, 0, 0, 0, 16'd0, 16'd0, 16'd0, 16'd3, 16'd2);
        drive(-1, 3); wait_drain();

        // 32-byte runt with good FCS
        build_ip(28); add_fcs(); make_burst(7);
        set_exp(0, 0, 0, 1, 0, 16'd32, 16'h0800, 16'd0, 16'd4, 16'd3);
        drive(-1, 3); wait_drain();

        // 1530-byte oversize frame
        build_ip(1526); add_fcs(); make_burst(7);
        set_exp(0, 0, 0, 0, 1, 16'd1530, 16'h0800, 16'd0, 16'd5, 16'd4);
        drive(-1, 3); wait_drain();

        // Exactly MAX_LEN is accepted
        build_ip(1518); add_fcs(); make_burst(1);
        set_exp(1, 0, 0, 0, 0, 16'd1522, 16'h0800, 16'd0, 16'd6, 16'd4);
        drive(-1, 3); wait_drain();

        // Reset clears counters and status
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        check_zero();

        // Three back-to-back ARP frames with a single idle cycle between them
        build_arp(); add_fcs(); make_burst(7);
        for (int k = 1; k <= 3; k++) begin
            set_exp(1, 0, 0, 0, 0, 16'd64, 16'h0806, 16'h0001, 16'(k), 16'd0);
            drive(-1, 1);
        end
        wait_drain();

        // Reset at data byte 20 (7 preamble + SFD precede it)
        build_arp(); add_fcs(); make_burst(7);
        set_exp(0, 1, 0, 0, 0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1);
        drive(28, 3); wait_drain();

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
